enemy_mover: RTL and testbench
==============================

Name: enemy_mover

Overview:
- Parametrised successor to the single-step enemy sweep.
- On `start`, and only when the move period has elapsed, raster-scans a GRID_W x GRID_H cell map and moves every enemy cell by at most one cell.
  - Random mode: LFSR direction with clockwise retry.
  - Chase mode: steps toward the player.
- A mark-then-fixup second pass guarantees no enemy moves twice in one sweep.
- Sits between the game-tick controller and the shared grid memory port.

Parameters:
- GRID_W, 40: grid columns.
- GRID_H, 30: grid rows.
- X_W, 6: grid_x width; must satisfy 2^X_W >= GRID_W.
- Y_W, 5: grid_y width; must satisfy 2^Y_W >= GRID_H.
- CELL_W, 3: cell code width.
- AIR_CODE, 0: empty cell.
- ENEMY_CODE, 4: enemy cell.
- MOVED_CODE, 5: transient "moved this sweep" marker.
- PERIOD, 200000: minimum clock cycles between completed sweeps.
- RD_LAT, 1: grid read latency in cycles (addr to grid_out), must be >= 1.
- CNT_W, 8: moved_count width.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- start, in, 1: request a sweep; sampled only in IDLE.
- mode, in, 1: 0 = random, 1 = chase; sampled at start.
- player_x, in, X_W: player column; sampled at start.
- player_y, in, Y_W: player row; sampled at start.
- done, out, 1: one-cycle pulse when request finishes (moved or skipped).
- grid_x, out, X_W: grid address column.
- grid_y, out, Y_W: grid address row.
- grid_out, in, CELL_W: read data, valid RD_LAT cycles after address.
- grid_write, out, 1: write strobe for grid_in at (grid_x, grid_y).
- grid_in, out, CELL_W: write data.
- moved_count, out, CNT_W: enemies moved in last completed sweep; saturating.

Behaviour:
- Reset:
  - state IDLE; done=0, grid_write=0, grid_x=0, grid_y=0, grid_in=0, moved_count=0.
  - Period counter loads PERIOD; LFSR seeds 8'h01.
- Period counter:
  - Decrements every cycle, saturates at 0.
  - Reloads PERIOD in the DONE state of a sweep that actually ran.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle.
  - dir = lfsr[1:0], latched at SCAN_EVAL.
  - Direction encoding: 0 = up (y-1), 1 = right (x+1), 2 = down (y+1), 3 = left (x-1).
- States:
  - IDLE: start → GATE; start is ignored in every other state.
  - GATE: if counter==0, latch mode/player, clear cursor (0,0) and run counter, → SCAN_RD; else → DONE (skip; moved_count unchanged).
  - SCAN_RD/SCAN_WAIT: address = cursor; wait RD_LAT cycles.
  - SCAN_EVAL: if grid_out==ENEMY_CODE, build candidate list, → CAND_RD; else → SCAN_NEXT.
  - CAND_RD/CAND_WAIT: address = current candidate.
  - CAND_EVAL: if grid_out==AIR_CODE → WRITE_NEW; else advance to next candidate (→ CAND_RD), or → SCAN_NEXT if the list is exhausted.
  - WRITE_NEW: one cycle, grid_write=1, grid_in=MOVED_CODE at candidate.
  - ERASE_OLD: one cycle, grid_write=1, grid_in=AIR_CODE at cursor; run counter +1 saturating; → SCAN_NEXT.
  - SCAN_NEXT: raster increment (x wraps at GRID_W-1, y increments); after (GRID_W-1, GRID_H-1) → FIX_RD with cursor (0,0).
  - FIX_RD/FIX_WAIT/FIX_EVAL: read cursor; if MOVED_CODE → FIX_WR (write ENEMY_CODE); then FIX_NEXT.
  - FIX_NEXT: after last cell → DONE.
  - DONE: done=1 for one cycle, moved_count <= run counter (ran sweeps only), → IDLE.
- grid_write is asserted only in WRITE_NEW, ERASE_OLD, FIX_WR; never two consecutive-cycle writes to the same address.
- Candidates, random mode: dir, dir+1, dir+2, dir+3 (mod 4), at most 4 tries.
- Candidates, chase mode:
  - dx = player_x - x, dy = player_y - y (signed, X_W+1 / Y_W+1 bits).
  - Primary axis = larger |d|; tie → x axis. Secondary = other axis.
  - An axis with d==0 is omitted. Both zero → empty list, no move.
- Edge handling: a candidate outside [0,GRID_W-1] x [0,GRID_H-1] is blocked without a read (no wrap, no address issued).
- MOVED_CODE cells are not ENEMY_CODE, so moved enemies are never re-moved in the same scan.
- Reset mid-sweep: returns to IDLE next edge with grid_write=0. Cells already marked MOVED_CODE are not repaired; the top level reinitialises the map after any reset.

Test Plan:
- PERIOD=10, start at cycle 3 after reset → done pulses exactly 2 cycles later, no grid_write, moved_count=0.
- Random mode, 5x5 grid (GRID_W=GRID_H=5), single enemy at (2,2), all else air, LFSR forced so dir=1 → write MOVED_CODE at (3,2), AIR at (2,2), fixup writes ENEMY_CODE at (3,2), moved_count=1.
- Enemy at (0,0), walls (code 1) at (1,0) and (0,1), random mode → no writes; out-of-range up/left issue no read address; moved_count=0.
- Enemies at (1,1) and (2,1), rightward path clear → each moves at most once; final enemies at (2,1)→(3,1) and (1,1) blocked then tries down to (1,2); no cell holds MOVED_CODE at done.
- Chase mode, enemy (1,1), player (4,2), wall at (2,1) → primary x blocked, secondary down taken: enemy ends at (1,2).
- Assert reset during WRITE_NEW → next cycle state IDLE, grid_write=0, done=0; subsequent start with counter>0 skips.

Source files
------------

// File: rtl/enemy_mover_if.sv
// Shared grid memory port between enemy_mover (master) and the grid RAM (slave).
//   grid_x, grid_y : cell address (column, row)
//   grid_write     : write strobe, stores grid_in at (grid_x, grid_y)
//   grid_in        : write data
//   grid_out       : read data, valid a fixed number of cycles after the address
interface enemy_mover_if #(
    parameter int X_W    = 6,
    parameter int Y_W    = 5,
    parameter int CELL_W = 3
) ();
    logic [X_W-1:0]    grid_x;
    logic [Y_W-1:0]    grid_y;
    logic              grid_write;
    logic [CELL_W-1:0] grid_in;
    logic [CELL_W-1:0] grid_out;

    modport master (
        output grid_x,
        output grid_y,
        output grid_write,
        output grid_in,
        input  grid_out
    );

    modport slave (
        input  grid_x,
        input  grid_y,
        input  grid_write,
        input  grid_in,
        output grid_out
    );
endinterface

// File: rtl/enemy_mover.sv
// enemy_mover: rate-limited sweep that moves every enemy cell of the grid map
// by at most one cell, either in a random direction (with clockwise retry) or
// toward the player. Moved enemies are first marked MOVED_CODE so the raster
// scan cannot pick them up again; a second pass turns the marks back into
// ENEMY_CODE.
//   clock, reset          : clock, synchronous active-high reset
//   start                 : sweep request, honoured only while idle
//   mode                  : 0 = random, 1 = chase (latched when the sweep runs)
//   player_x, player_y    : player position (latched when the sweep runs)
//   done                  : one-cycle pulse when a request finishes or is skipped
//   moved_count           : enemies moved in the last sweep that ran (saturating)
//   grid                  : grid memory port (address, read data, write strobe/data)
module enemy_mover #(
    parameter int                GRID_W     = 40,
    parameter int                GRID_H     = 30,
    parameter int                X_W        = 6,
    parameter int                Y_W        = 5,
    parameter int                CELL_W     = 3,
    parameter logic [CELL_W-1:0] AIR_CODE   = CELL_W'(0),
    parameter logic [CELL_W-1:0] ENEMY_CODE = CELL_W'(4),
    parameter logic [CELL_W-1:0] MOVED_CODE = CELL_W'(5),
    parameter int                PERIOD     = 200000,
    parameter int                RD_LAT     = 1,
    parameter int                CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [X_W-1:0]   player_x,
    input  logic [Y_W-1:0]   player_y,
    output logic             done,
    output logic [CNT_W-1:0] moved_count,
    enemy_mover_if.master    grid
);

    localparam int PER_W  = ($clog2(PERIOD + 1) > 0) ? $clog2(PERIOD + 1) : 1;
    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int D_W    = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

    typedef enum logic [4:0] {
        IDLE, GATE,
        SCAN_RD, SCAN_WAIT, SCAN_EVAL,
        CAND_RD, CAND_WAIT, CAND_EVAL,
        WRITE_NEW, ERASE_OLD, SCAN_NEXT,
        FIX_RD, FIX_WAIT, FIX_EVAL, FIX_WR, FIX_NEXT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    state_t            state, state_next;
    logic [PER_W-1:0]  per_cnt;
    logic [7:0]        lfsr;
    logic              lfsr_fb;
    logic              ran;
    logic              mode_q;
    logic [X_W-1:0]    px_q, cur_x, cand_x;
    logic [Y_W-1:0]    py_q, cur_y, cand_y;
    logic [CNT_W-1:0]  run_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    dir_t              cand_dir  [4];
    dir_t              build_dir [4];
    dir_t              cur_dir, x_dir, y_dir;
    logic [2:0]        cand_n, build_n, cand_idx;
    logic              cand_ok, last_cand, last_cell, wait_done, per_zero, use_cand;
    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    logic [X_W:0]      ax;
    logic [Y_W:0]      ay;
    logic [D_W-1:0]    ax_e, ay_e;

    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign per_zero  = (per_cnt == '0);
    assign wait_done = (wait_cnt == WAIT_W'(RD_LAT - 1));
    assign last_cell = (cur_x == X_LAST) && (cur_y == Y_LAST);
    assign last_cand = ((cand_idx + 3'd1) >= cand_n);

    // Current candidate cell; cand_ok is low when the step would leave the grid,
    // in which case the candidate is dropped without issuing an address.
    always_comb begin
        cur_dir = cand_dir[cand_idx[1:0]];
        cand_x  = cur_x;
        cand_y  = cur_y;
        cand_ok = 1'b0;
        case (cur_dir)
            DIR_UP: begin
                cand_ok = (cur_y != '0);
                cand_y  = cur_y - Y_W'(1);
            end
            DIR_RIGHT: begin
                cand_ok = (cur_x != X_LAST);
                cand_x  = cur_x + X_W'(1);
            end
            DIR_DOWN: begin
                cand_ok = (cur_y != Y_LAST);
                cand_y  = cur_y + Y_W'(1);
            end
            DIR_LEFT: begin
                cand_ok = (cur_x != '0);
                cand_x  = cur_x - X_W'(1);
            end
            default: ;
        endcase
    end

    // Candidate list for the enemy under the cursor.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            build_dir[i] = DIR_UP;
        end
        build_n = 3'd0;
        dx      = $signed({1'b0, px_q}) - $signed({1'b0, cur_x});
        dy      = $signed({1'b0, py_q}) - $signed({1'b0, cur_y});
        ax      = dx[X_W] ? $unsigned(-dx) : $unsigned(dx);
        ay      = dy[Y_W] ? $unsigned(-dy) : $unsigned(dy);
        ax_e    = D_W'(ax);
        ay_e    = D_W'(ay);
        x_dir   = dx[X_W] ? DIR_LEFT : DIR_RIGHT;
        y_dir   = dy[Y_W] ? DIR_UP : DIR_DOWN;
        if (!mode_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                build_dir[i] = dir_t'(lfsr[1:0] + 2'(i));
            end
            build_n = 3'd4;
        end else if (dx == '0 && dy == '0) begin
            build_n = 3'd0;
        end else if (dx == '0) begin
            build_dir[0] = y_dir;
            build_n      = 3'd1;
        end else if (dy == '0) begin
            build_dir[0] = x_dir;
            build_n      = 3'd1;
        end else if (ax_e >= ay_e) begin
            build_dir[0] = x_dir;
            build_dir[1] = y_dir;
            build_n      = 3'd2;
        end else begin
            build_dir[0] = y_dir;
            build_dir[1] = x_dir;
            build_n      = 3'd2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        done            = 1'b0;
        grid.grid_write = 1'b0;
        grid.grid_in    = '0;
        use_cand        = 1'b0;
        case (state)
            IDLE:      if (start) state_next = GATE;
            GATE:      state_next = per_zero ? SCAN_RD : DONE;
            SCAN_RD:   state_next = SCAN_WAIT;
            SCAN_WAIT: if (wait_done) state_next = SCAN_EVAL;
            SCAN_EVAL: state_next = (grid.grid_out == ENEMY_CODE && build_n != 3'd0)
                                    ? CAND_RD : SCAN_NEXT;
            CAND_RD: begin
                use_cand = cand_ok;
                if (cand_ok)        state_next = CAND_WAIT;
                else if (last_cand) state_next = SCAN_NEXT;
            end
            CAND_WAIT: begin
                use_cand = 1'b1;
                if (wait_done) state_next = CAND_EVAL;
            end
            CAND_EVAL: begin
                use_cand = 1'b1;
                if (grid.grid_out == AIR_CODE) state_next = WRITE_NEW;
                else                           state_next = last_cand ? SCAN_NEXT : CAND_RD;
            end
            WRITE_NEW: begin
                use_cand        = 1'b1;
                grid.grid_write = 1'b1;
                grid.grid_in    = MOVED_CODE;
                state_next      = ERASE_OLD;
            end
            ERASE_OLD: begin
                grid.grid_write = 1'b1;
                grid.grid_in    = AIR_CODE;
                state_next      = SCAN_NEXT;
            end
            SCAN_NEXT: state_next = last_cell ? FIX_RD : SCAN_RD;
            FIX_RD:    state_next = FIX_WAIT;
            FIX_WAIT:  if (wait_done) state_next = FIX_EVAL;
            FIX_EVAL:  state_next = (grid.grid_out == MOVED_CODE) ? FIX_WR : FIX_NEXT;
            FIX_WR: begin
                grid.grid_write = 1'b1;
                grid.grid_in    = ENEMY_CODE;
                state_next      = FIX_NEXT;
            end
            FIX_NEXT:  state_next = last_cell ? DONE : FIX_RD;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
        grid.grid_x = use_cand ? cand_x : cur_x;
        grid.grid_y = use_cand ? cand_y : cur_y;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            per_cnt     <= PER_W'(PERIOD);
            lfsr        <= 8'h01;
            ran         <= 1'b0;
            mode_q      <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            run_cnt     <= '0;
            moved_count <= '0;
            wait_cnt    <= '0;
            cand_n      <= '0;
            cand_idx    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cand_dir[i] <= DIR_UP;
            end
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            if (state == DONE && ran) begin
                per_cnt <= PER_W'(PERIOD);
            end else if (!per_zero) begin
                per_cnt <= per_cnt - PER_W'(1);
            end
            case (state)
                GATE: begin
                    ran <= per_zero;
                    if (per_zero) begin
                        mode_q  <= mode;
                        px_q    <= player_x;
                        py_q    <= player_y;
                        cur_x   <= '0;
                        cur_y   <= '0;
                        run_cnt <= '0;
                    end
                end
                SCAN_RD, FIX_RD: wait_cnt <= '0;
                CAND_RD: begin
                    wait_cnt <= '0;
                    if (!cand_ok) cand_idx <= cand_idx + 3'd1;
                end
                SCAN_WAIT, CAND_WAIT, FIX_WAIT: wait_cnt <= wait_cnt + WAIT_W'(1);
                SCAN_EVAL: begin
                    cand_dir <= build_dir;
                    cand_n   <= build_n;
                    cand_idx <= '0;
                end
                CAND_EVAL: if (grid.grid_out != AIR_CODE) cand_idx <= cand_idx + 3'd1;
                ERASE_OLD: if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
                SCAN_NEXT, FIX_NEXT: begin
                    if (cur_x == X_LAST) begin
                        cur_x <= '0;
                        cur_y <= (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
                    end else begin
                        cur_x <= cur_x + X_W'(1);
                    end
                end
                DONE: if (ran) moved_count <= run_cnt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_mover.sv
// Directed bench for enemy_mover on a 5x5 grid with a behavioural 1-cycle-latency
// grid RAM. Writes are logged at the falling edge; expected writes and final maps
// are hand-computed per scenario.
module tb_enemy_mover;
    localparam int GW = 5, GH = 5, XW = 3, YW = 3, PER = 10;
    localparam int AIR = 0, WALL = 1, ENEMY = 4, MOVED = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode  = 1'b0;
    logic [XW-1:0] player_x = '0;
    logic [YW-1:0] player_y = '0;
    logic          done;
    logic [7:0]    moved_count;

    enemy_mover_if #(.X_W(XW), .Y_W(YW), .CELL_W(3)) bus ();

    enemy_mover #(
        .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW),
        .PERIOD(PER), .RD_LAT(1), .CNT_W(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .player_x(player_x), .player_y(player_y), .done(done),
        .moved_count(moved_count), .grid(bus)
    );

    always #5 clock = ~clock;

    // Grid RAM model: read-before-write, registered read data.
    logic [2:0] mem      [GH][GW];
    logic [2:0] init_map [GH][GW];
    logic       load_req = 1'b0;
    logic [2:0] rd_data;
    int         gx, gy;

    always @(posedge clock) begin
        gx = int'(bus.grid_x);
        gy = int'(bus.grid_y);
        rd_data = (gx < GW && gy < GH) ? mem[gy][gx] : 3'd0;
        if (load_req) mem = init_map;
        else if (bus.grid_write === 1'b1 && gx < GW && gy < GH) mem[gy][gx] = bus.grid_in;
        bus.grid_out <= rd_data;
    end

    int wq_x[$], wq_y[$], wq_d[$];
    int addr_bad = 0;

    always @(negedge clock) begin
        if (bus.grid_write === 1'b1) begin
            wq_x.push_back(int'(bus.grid_x));
            wq_y.push_back(int'(bus.grid_y));
            wq_d.push_back(int'(bus.grid_in));
        end
        if (int'(bus.grid_x) >= GW || int'(bus.grid_y) >= GH) addr_bad++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Write entries are compared as x*100 + y*10 + data.
    task automatic check_write(input string tag, input int idx, input int x, input int y, input int d);
        int got;
        got = -1;
        if (idx < wq_x.size()) got = wq_x[idx] * 100 + wq_y[idx] * 10 + wq_d[idx];
        check(tag, got, x * 100 + y * 10 + d);
    endtask

    task automatic clear_map();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                init_map[y][x] = 3'(AIR);
    endtask

    task automatic set_cell(input int x, input int y, input int code);
        init_map[y][x] = 3'(code);
    endtask

    task automatic apply_map();
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
    endtask

    function automatic int count_code(input int code);
        int n;
        n = 0;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                if (int'(mem[y][x]) == code) n++;
        return n;
    endfunction

    task automatic run_sweep(input string tag, output int cyc);
        repeat (PER + 4) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_done_seen"}, int'(done === 1'b1), 1);
        check({tag, "_ran"}, int'(cyc > 2), 1);
        @(negedge clock);
    endtask

    initial begin
        int cyc, base, bad0, found;

        clear_map();
        repeat (2) @(negedge clock);
        apply_map();
        @(negedge clock);
        check("rst_done", int'(done), 0);
        check("rst_grid_write", int'(bus.grid_write), 0);
        check("rst_grid_x", int'(bus.grid_x), 0);
        check("rst_grid_y", int'(bus.grid_y), 0);
        check("rst_grid_in", int'(bus.grid_in), 0);
        check("rst_moved_count", int'(moved_count), 0);

        // Early request: period not yet elapsed, request is skipped.
        reset = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("skip_done_gate", int'(done), 0);
        @(negedge clock);
        check("skip_done_pulse", int'(done), 1);
        @(negedge clock);
        check("skip_done_low", int'(done), 0);
        check("skip_no_write", wq_x.size(), 0);
        check("skip_moved_count", int'(moved_count), 0);

        // Random mode with direction pinned to 1 (right).
        force dut.lfsr = 8'h01;
        clear_map();
        set_cell(2, 2, ENEMY);
        apply_map();
        base = wq_x.size();
        run_sweep("rnd", cyc);
        check("rnd_wr_count", wq_x.size() - base, 3);
        check_write("rnd_wr_new", base, 3, 2, MOVED);
        check_write("rnd_wr_erase", base + 1, 2, 2, AIR);
        check_write("rnd_wr_fix", base + 2, 3, 2, ENEMY);
        check("rnd_final_cell", int'(mem[2][3]), ENEMY);
        check("rnd_moved_count", int'(moved_count), 1);

        // Corner enemy boxed in by walls; up/left fall off the grid.
        clear_map();
        set_cell(0, 0, ENEMY);
        set_cell(1, 0, WALL);
        set_cell(0, 1, WALL);
        apply_map();
        base = wq_x.size();
        bad0 = addr_bad;
        run_sweep("corner", cyc);
        check("corner_wr_count", wq_x.size() - base, 0);
        check("corner_addr_range", addr_bad - bad0, 0);
        check("corner_enemy_kept", int'(mem[0][0]), ENEMY);
        check("corner_moved_count", int'(moved_count), 0);

        // Two adjacent enemies: (1,1) blocked right then moves down, (2,1) moves right.
        clear_map();
        set_cell(1, 1, ENEMY);
        set_cell(2, 1, ENEMY);
        apply_map();
        base = wq_x.size();
        run_sweep("pair", cyc);
        check("pair_wr_count", wq_x.size() - base, 6);
        check_write("pair_wr0", base, 1, 2, MOVED);
        check_write("pair_wr1", base + 1, 1, 1, AIR);
        check_write("pair_wr2", base + 2, 3, 1, MOVED);
        check_write("pair_wr3", base + 3, 2, 1, AIR);
        check_write("pair_wr4", base + 4, 3, 1, ENEMY);
        check_write("pair_wr5", base + 5, 1, 2, ENEMY);
        check("pair_no_moved_left", count_code(MOVED), 0);
        check("pair_enemy_total", count_code(ENEMY), 2);
        check("pair_moved_count", int'(moved_count), 2);

        // Chase, enemy already on the player: empty candidate list.
        mode = 1'b1;
        player_x = 3'd4;
        player_y = 3'd2;
        clear_map();
        set_cell(4, 2, ENEMY);
        apply_map();
        base = wq_x.size();
        run_sweep("chase_same", cyc);
        check("chase_same_wr_count", wq_x.size() - base, 0);
        check("chase_same_moved_count", int'(moved_count), 0);

        // Chase: primary x axis blocked by a wall, secondary down taken.
        clear_map();
        set_cell(1, 1, ENEMY);
        set_cell(2, 1, WALL);
        apply_map();
        base = wq_x.size();
        run_sweep("chase", cyc);
        check("chase_wr_count", wq_x.size() - base, 3);
        check_write("chase_wr_new", base, 1, 2, MOVED);
        check_write("chase_wr_erase", base + 1, 1, 1, AIR);
        check_write("chase_wr_fix", base + 2, 1, 2, ENEMY);
        check("chase_moved_count", int'(moved_count), 1);
        mode = 1'b0;

        // Reset while WRITE_NEW is on the bus.
        clear_map();
        set_cell(2, 2, ENEMY);
        apply_map();
        repeat (PER + 4) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            if (bus.grid_write === 1'b1 && int'(bus.grid_in) == MOVED) found = 1;
            else @(negedge clock);
        end
        check("midrst_hit_write_new", found, 1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_grid_write", int'(bus.grid_write), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_grid_x", int'(bus.grid_x), 0);
        check("midrst_moved_count", int'(moved_count), 0);
        base = wq_x.size();
        reset = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("midrst_skip_gate", int'(done), 0);
        @(negedge clock);
        check("midrst_skip_done", int'(done), 1);
        check("midrst_skip_no_write", wq_x.size() - base, 0);

        release dut.lfsr;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
